// File: rtl/keypad_pkg.sv
// Shared definitions for the two-digit keypad entry controller.
// Holds the key-line width, the entry state encoding and the
// one-hot-to-BCD decoder used when a debounced press is accepted.
package keypad_pkg;

  localparam int KEY_W = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Key line i carries digit 10-i, except line 0 which carries 0.
  // Higher indices overwrite lower ones, so the highest set line wins.
  function automatic logic [3:0] onehot_to_bcd(input logic [KEY_W-1:0] keys);
    logic [3:0] bcd;
    bcd = 4'd0;
    for (int i = 1; i < KEY_W; i++) begin
      if (keys[i]) bcd = 4'(KEY_W - i);
    end
    return bcd;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser, debounce counter and press/release arming for the raw
// keypad lines.
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   keys_i     raw asynchronous key lines
//   strobe_o   one-cycle pulse when a stable nonzero pattern is accepted
//   pattern_o  synchronised key pattern (valid to decode while strobe_o=1)
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] keys_i,
  output logic             strobe_o,
  output logic [KEY_W-1:0] pattern_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [KEY_W-1:0] sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             same, at_last;

  // Two-flop synchroniser plus a copy of the previous synchronised sample.
  // Armed comes out of reset cleared so a key held through reset is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= keys_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // The counter saturates at its terminal value so a long hold can never
  // wrap round and look like a fresh stable run.
  always_comb begin
    same     = (sync2_q == prev_q);
    at_last  = (cnt_q == CNT_LAST);
    cnt_d    = '0;
    armed_d  = armed_q;
    strobe_o = 1'b0;
    if (same) begin
      cnt_d = at_last ? cnt_q : cnt_q + CNT_W'(1);
    end
    if (same && at_last && armed_q && (sync2_q != '0)) begin
      strobe_o = 1'b1;
      armed_d  = 1'b0;
    end else if (same && at_last && (sync2_q == '0)) begin
      armed_d = 1'b1;
    end
  end

  assign pattern_o = sync2_q;

endmodule

// File: rtl/keypad_2digit_ctrl.sv
// Two-digit decimal keypad entry controller. Debounced key presses are
// shifted calculator-style into units/tens registers; enter commits the
// number, which is then held with valid_o until the consumer acks.
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset
//   dig_i    raw key lines, dig_i[9]=1 ... dig_i[1]=9, dig_i[0]=0
//   clr_i    synchronous clear of the entry (pulse)
//   enter_i  commit the current entry (pulse)
//   ack_i    consumer has taken the value (used only while valid_o=1)
//   uni_o    units digit, BCD
//   dec_o    tens digit, BCD
//   value_o  binary value dec*10+uni
//   count_o  number of digits entered (0..2)
//   valid_o  entry committed and held
//   err_o    one-cycle pulse on a rejected action
module keypad_2digit_ctrl
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] dig_i,
  input  logic             clr_i,
  input  logic             enter_i,
  input  logic             ack_i,
  output logic [3:0]       uni_o,
  output logic [3:0]       dec_o,
  output logic [6:0]       value_o,
  output logic [1:0]       count_o,
  output logic             valid_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  logic [3:0]       uni_q, uni_d, dec_q, dec_d;
  logic [6:0]       value_q, value_d;
  logic [1:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             key_stb;
  logic [KEY_W-1:0] key_pat;
  logic [3:0]       key_digit;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .keys_i   (dig_i),
    .strobe_o (key_stb),
    .pattern_o(key_pat)
  );

  assign key_digit = onehot_to_bcd(key_pat);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      uni_q   <= '0;
      dec_q   <= '0;
      value_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uni_q   <= uni_d;
      dec_q   <= dec_d;
      value_q <= value_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Priority: clr, then ack (DONE only), then enter, then key strobe.
  // Enter always shadows a simultaneous key, so the key is simply dropped.
  always_comb begin
    state_d = state_q;
    uni_d   = uni_q;
    dec_d   = dec_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (clr_i) begin
      state_d = EMPTY;
      uni_d   = '0;
      dec_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enter_i) begin
            err_d = 1'b1;
          end else if (key_stb) begin
            uni_d   = key_digit;
            dec_d   = '0;
            count_d = 2'd1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (enter_i) begin
            state_d = DONE;
          end else if (key_stb) begin
            dec_d   = uni_q;
            uni_d   = key_digit;
            count_d = 2'd2;
            state_d = TWO;
          end
        end
        TWO: begin
          if (enter_i) begin
            state_d = DONE;
          end else if (key_stb) begin
            err_d = 1'b1;
          end
        end
        DONE: begin
          if (ack_i) begin
            state_d = EMPTY;
            uni_d   = '0;
            dec_d   = '0;
            count_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Always derived from the next digits so it moves on the same edge.
    value_d = {3'b000, dec_d} * 7'd10 + {3'b000, uni_d};
  end

  assign uni_o   = uni_q;
  assign dec_o   = dec_q;
  assign value_o = value_q;
  assign count_o = count_q;
  assign valid_o = (state_q == DONE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_keypad_2digit_ctrl.sv
// Self-checking bench for keypad_2digit_ctrl. The stimulus process queues
// the expected output snapshot for every change it causes; a monitor pops
// one entry each time the observed output snapshot changes.
module tb_keypad_2digit_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] dig;
  logic       clr, enter, ack;
  logic [3:0] uni, dec;
  logic [6:0] value;
  logic [1:0] count;
  logic       valid, err;

  logic [18:0] curSnap;
  logic [18:0] lastSnap;
  logic        monOn = 1'b0;
  int          nChecks = 0;
  int          nPass = 0;

  typedef struct {
    logic [18:0] snap;
    string       name;
  } exp_t;

  exp_t expQ[$];

  keypad_2digit_ctrl #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .dig_i  (dig),
    .clr_i  (clr),
    .enter_i(enter),
    .ack_i  (ack),
    .uni_o  (uni),
    .dec_o  (dec),
    .value_o(value),
    .count_o(count),
    .valid_o(valid),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  assign curSnap = {uni, dec, value, count, valid, err};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act === expv) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  task automatic expectSnap(input string name, input logic [3:0] u, input logic [3:0] d,
                            input logic [6:0] v, input logic [1:0] c, input logic va,
                            input logic er);
    exp_t e;
    e.snap = {u, d, v, c, va, er};
    e.name = name;
    expQ.push_back(e);
  endtask

  // One-cycle pulse on any of clr/enter/ack, launched from a falling edge.
  task automatic applyStimulus(input logic c, input logic e, input logic a);
    @(negedge clk);
    clr = c; enter = e; ack = a;
    @(negedge clk);
    clr = 1'b0; enter = 1'b0; ack = 1'b0;
  endtask

  task automatic pressKeys(input logic [9:0] pat);
    @(negedge clk);
    dig = pat;
    repeat (DEB + 6) @(negedge clk);
    dig = '0;
    repeat (DEB + 6) @(negedge clk);
  endtask

  // Monitor: every change of the output snapshot must match the next entry.
  initial begin
    lastSnap = '0;
    wait (monOn);
    lastSnap = curSnap;
    forever begin
      @(negedge clk);
      if (curSnap !== lastSnap) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedChange", 32'(curSnap), 32'(lastSnap));
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput(e.name, 32'(curSnap), 32'(e.snap));
        end
        lastSnap = curSnap;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; dig = '0; clr = 1'b0; enter = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetState", 32'(curSnap), 32'd0);
    rst = 1'b0;
    monOn = 1'b1;
    repeat (10) @(negedge clk);

    // Enter with nothing typed is rejected with a single-cycle err.
    expectSnap("enterEmptyErr", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b1);
    expectSnap("enterEmptyErrEnd", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Key 2 bouncing, then held: one accept, six edges after the hold starts.
    expectSnap("bounceKey2", 4'd2, 4'd0, 7'd2, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dig = (i % 2 == 0) ? 10'b01_0000_0000 : 10'b0;
    end
    @(negedge clk);
    dig = 10'b01_0000_0000;
    repeat (6) @(negedge clk);
    checkOutput("latencyEarly", 32'(uni), 32'd0);
    @(negedge clk);
    checkOutput("latencyOnTime", 32'(uni), 32'd2);
    repeat (100) @(negedge clk);
    checkOutput("holdNoRepeat", 32'(count), 32'd1);
    dig = '0;
    repeat (10) @(negedge clk);
    expectSnap("clrAfterKey2", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Two-digit entry 4,7 then commit and handshake.
    expectSnap("key4", 4'd4, 4'd0, 7'd4, 2'd1, 1'b0, 1'b0);
    pressKeys(10'b00_0100_0000);
    expectSnap("key7", 4'd7, 4'd4, 7'd47, 2'd2, 1'b0, 1'b0);
    pressKeys(10'b00_0000_1000);
    expectSnap("commit47", 4'd7, 4'd4, 7'd47, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("validHeld", 32'(valid), 32'd1);
    expectSnap("ack47", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Third digit is rejected; 90 is committed; keys ignored in DONE.
    expectSnap("key9", 4'd9, 4'd0, 7'd9, 2'd1, 1'b0, 1'b0);
    pressKeys(10'b00_0000_0010);
    expectSnap("key0", 4'd0, 4'd9, 7'd90, 2'd2, 1'b0, 1'b0);
    pressKeys(10'b00_0000_0001);
    expectSnap("overflowErr", 4'd0, 4'd9, 7'd90, 2'd2, 1'b0, 1'b1);
    expectSnap("overflowErrEnd", 4'd0, 4'd9, 7'd90, 2'd2, 1'b0, 1'b0);
    pressKeys(10'b00_0010_0000);
    expectSnap("commit90", 4'd0, 4'd9, 7'd90, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pressKeys(10'b00_0010_0000);
    checkOutput("doneIgnoresKey", 32'(curSnap), 32'({4'd0, 4'd9, 7'd90, 2'd2, 1'b1, 1'b0}));
    expectSnap("ack90", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Two lines at once: the highest index (key 1) wins over key 8.
    expectSnap("multiKey", 4'd1, 4'd0, 7'd1, 2'd1, 1'b0, 1'b0);
    pressKeys(10'b10_0000_0100);
    expectSnap("clrMulti", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // clr beats enter in the same cycle.
    expectSnap("key3", 4'd3, 4'd0, 7'd3, 2'd1, 1'b0, 1'b0);
    pressKeys(10'b00_1000_0000);
    expectSnap("key1", 4'd1, 4'd3, 7'd31, 2'd2, 1'b0, 1'b0);
    pressKeys(10'b10_0000_0000);
    expectSnap("clrBeatsEnter", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("noValidAfterClr", 32'(valid), 32'd0);

    // Reset between clock edges while a value is held.
    expectSnap("key4b", 4'd4, 4'd0, 7'd4, 2'd1, 1'b0, 1'b0);
    pressKeys(10'b00_0100_0000);
    expectSnap("key7b", 4'd7, 4'd4, 7'd47, 2'd2, 1'b0, 1'b0);
    pressKeys(10'b00_0000_1000);
    expectSnap("commit47b", 4'd7, 4'd4, 7'd47, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("validBeforeRst", 32'(valid), 32'd1);
    expectSnap("rstClears", 4'd0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncValidDrop", 32'(valid), 32'd0);
    checkOutput("asyncValueClear", 32'(value), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/keypad_2digit_ctrl.md
Name: keypad_2digit_ctrl

Overview:
- Sequencing controller for two-digit decimal keypad entry.
- Synchronises and debounces the 10 one-hot key lines, converts each accepted press to BCD, and shifts digits into units/tens registers calculator-style.
- Presents a held, validated two-digit number with a binary equivalent to downstream logic through a valid/ack handshake.
- Sits between the raw keypad pins and any consumer of the entered number.

Parameters:
- DEB_CYCLES, 4, consecutive identical nonzero samples required to accept a key; also consecutive all-zero samples required to re-arm (range 2..255).
- CNT_W, 8, width of the debounce counter; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- dig  in  10  raw key lines; dig[9]=1, dig[8]=2 … dig[1]=9, dig[0]=0
- clr  in  1  synchronous clear of the entry, one-cycle pulse
- enter  in  1  commit the current entry, one-cycle pulse
- ack  in  1  consumer has taken the value; meaningful only while valid=1
- uni  out  4  units digit, BCD
- dec  out  4  tens digit, BCD
- value  out  7  binary value dec*10+uni, range 0..99
- count  out  2  digits entered: 0, 1 or 2
- valid  out  1  entry committed and held
- err  out  1  one-cycle pulse on a rejected action

Behaviour:
- Reset (async, rst=1): uni=0, dec=0, value=0, count=0, valid=0, err=0, state=EMPTY. The synchroniser and debounce counter clear and the key logic is disarmed-safe: it requires a release before the first press.
- Input path: two-flop synchroniser on dig. The debounce counter increments while the synchronised pattern equals the previous sample; any change reloads the counter to 0.
- Accept: the pattern is nonzero, the logic is armed, and the counter reaches DEB_CYCLES-1. This produces a one-cycle key strobe, after which the logic disarms. It re-arms only after the pattern is all-zero for DEB_CYCLES samples.
- Latency: a clean press reaches the registers DEB_CYCLES+2 edges after the first stable edge of dig.
- Multi-key patterns: the highest set index wins (dig[9] highest, mapping 1 first). The winning digit is determined at the accept cycle.
- State EMPTY:
  - key strobe -> uni=d, dec=0, count=1, go to ONE.
  - enter -> err pulse, stay in EMPTY.
- State ONE:
  - key strobe -> dec=uni, uni=d, count=2, go to TWO.
  - enter -> go to DONE.
- State TWO:
  - key strobe -> digits unchanged, err pulse.
  - enter -> go to DONE.
- State DONE:
  - valid=1, and uni/dec/value are frozen.
  - key strobes and enter are ignored, with no err pulse.
  - ack -> next edge: valid=0, uni=dec=value=0, count=0, go to EMPTY.
- value: updated on the same edge as uni/dec, computed from the new digits as dec*10+uni, width 7, no overflow possible.
- clr: in any state, next edge gives EMPTY with digits, value and count at 0 and valid=0. It does not touch the debounce/arm state.
- Same-cycle priority, highest first: rst > clr > ack (DONE only) > enter > key strobe.
  - enter and key strobe together in ONE or TWO: commit the old digits and drop the key, no err.
  - enter and key strobe together in EMPTY: err pulse, drop the key.
- err: at most one pulse per cycle, never asserted during reset.
- Reset asserted mid-entry or mid-handshake: immediate return to the reset values. valid drops asynchronously.

Decomposition:
- Shared package keypad_pkg:
  - state enum (EMPTY=0, ONE=1, TWO=2, DONE=3)
  - function onehot_to_bcd(10-bit) -> 4-bit, highest-index priority, 0 for all-zero
  - constant KEY_W=10
- Sub-module key_debounce (parameters DEB_CYCLES, CNT_W): contains the synchroniser, counter and arm logic. Outputs strobe and the 10-bit stable pattern.
- Top level holds the FSM, digit registers and value arithmetic.

Test Plan:
- Reset and idle:
  - rst pulse with dig=0 -> all outputs 0, count=0.
  - enter alone -> err pulse of exactly 1 cycle, state stays EMPTY.
- Debounce:
  - dig[8] (key 2) bouncing 1-0-1 every cycle for 10 cycles, then held, DEB_CYCLES=4 -> exactly one accept.
  - uni=2 on edge 6 after stable hold begins; holding the key 100 cycles gives no second accept.
- Two-digit entry:
  - press 4 (dig[6]), release, press 7 (dig[3]), enter -> dec=4, uni=7, value=47, count=2.
  - valid=1 held until ack; the edge after ack gives all 0 and valid=0.
- Overflow:
  - press 9, 0, 5, then enter -> third key raises err, digits stay dec=9, uni=0.
  - value=90 with valid=1.
- Priority and held state:
  - with dec=3, uni=1, clr and enter in the same cycle -> EMPTY, digits 0, valid=0.
  - in DONE, key 5 pressed -> digits unchanged, err=0.
- Reset mid-handshake: valid=1 and value=47, rst asserted between edges -> valid=0 immediately, before the next clk edge.
